crc_code_encoder: RTL

//  Serial CRC-4 encoder (generator x^4+x+1): accepts an 8-bit data word, computes its
//  4-bit CRC one bit per clock in an LFSR, emits 12-bit codeword {data, crc}.

---
 rtl/crc_code_encoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/crc_code_encoder.sv
// Serial CRC-4 encoder: latches a data word, runs it MSB-first through an LFSR
// one bit per clock, and presents the codeword {data, crc} with valid/ready.
module crc_code_encoder #(
  parameter int unsigned          DATA_W = 8,
  parameter int unsigned          CRC_W  = 4,
  parameter logic [CRC_W-1:0]     POLY   = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W+CRC_W-1:0]   out_code,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned CODE_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CRC_W-1:0]    lfsr, lfsr_nx, lfsr_step_c;
  logic [DATA_W-1:0]   data_sr, data_sr_nx;
  logic [DATA_W-1:0]   data_hold, data_hold_nx;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [CODE_W-1:0]   out_code_nx;
  logic                out_valid_nx;
  logic                fb_c;

  // One LFSR step: shift left, fold feedback into the generator taps
  always_comb begin
    fb_c        = lfsr[CRC_W-1] ^ data_sr[DATA_W-1];
    lfsr_step_c = {lfsr[CRC_W-2:0], 1'b0} ^ (fb_c ? POLY : '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT)  state_nx = DONE;
      DONE:    if (out_ready)            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    lfsr_nx      = lfsr;
    data_sr_nx   = data_sr;
    data_hold_nx = data_hold;
    bit_cnt_nx   = bit_cnt;
    out_code_nx  = out_code;
    out_valid_nx = out_valid;
    case (state)
      IDLE: begin
        out_valid_nx = 1'b0;
        if (in_valid && in_ready) begin
          data_hold_nx = in_data;
          data_sr_nx   = in_data;
          lfsr_nx      = '0;
          bit_cnt_nx   = '0;
        end
      end
      SHIFT: begin
        lfsr_nx    = lfsr_step_c;
        data_sr_nx = {data_sr[DATA_W-2:0], 1'b0};
        bit_cnt_nx = bit_cnt + CNT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          out_code_nx  = {data_hold, lfsr_step_c};
          out_valid_nx = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) out_valid_nx = 1'b0;
      end
      default: begin
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= '0;
      data_sr   <= '0;
      data_hold <= '0;
      bit_cnt   <= '0;
      out_code  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      lfsr      <= lfsr_nx;
      data_sr   <= data_sr_nx;
      data_hold <= data_hold_nx;
      bit_cnt   <= bit_cnt_nx;
      out_code  <= out_code_nx;
      out_valid <= out_valid_nx;
      busy      <= (state_nx != IDLE);
      in_ready  <= (state_nx == IDLE);
    end
  end

endmodule
